// File: rtl/pipemem_stage.sv
// -----------------------------------------------------------------------------
// pipemem_stage
//   Memory stage of the pipeline. It captures the EXE results into the EX/MEM
//   register and performs the data-memory access over a req/ready bus with
//   variable latency. It then produces the MEM/WB register used by write-back.
//   While an access is outstanding, stall_mem freezes the upstream stages.
//
// Optional feature (compile-time macro):
//   MEM_MISALIGN_TRAP_EN - if defined, a memory op with malu[1:0] != 0 issues
//                          no request. It completes on the next edge as an
//                          abort (merr=1, wwreg=0, wmo=ERR_DATA).
//                          If undefined, the low address bits are ignored and
//                          the access is word-aligned.
//
// Parameters:
//   TIMEOUT  - number of stalled cycles allowed before a pending access is
//              aborted (1..255)
//   ERR_DATA - value written to wmo for an aborted access
//
// Ports:
//   clock, resetn                   rising-edge clock, async active-low reset
//   ewreg, em2reg, ewmem            EXE control: reg write, load, store
//   ealu, eb, ern                   EXE ALU result/address, store data, dest reg
//   dmem_req, dmem_we               memory request valid, write strobe
//   dmem_addr, dmem_wdata           word address, store data
//   dmem_ready, dmem_rdata          memory completion, read data
//   stall_mem                       freeze IF/ID/EXE and hold EX/MEM
//   mwreg, mm2reg, malu, mrn        EX/MEM register (forwarding view)
//   wwreg, wm2reg, walu, wmo, wrn   MEM/WB register
//   merr                            one-cycle pulse on an aborted access
// -----------------------------------------------------------------------------
module pipemem_stage #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        ewreg,
  input  logic        em2reg,
  input  logic        ewmem,
  input  logic [31:0] ealu,
  input  logic [31:0] eb,
  input  logic [4:0]  ern,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        stall_mem,
  output logic        mwreg,
  output logic        mm2reg,
  output logic [31:0] malu,
  output logic [4:0]  mrn,
  output logic        wwreg,
  output logic        wm2reg,
  output logic [31:0] walu,
  output logic [31:0] wmo,
  output logic [4:0]  wrn,
  output logic        merr
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;

  // EX/MEM register
  logic        mwreg_q, mm2reg_q, mwmem_q;
  logic [31:0] malu_q, mb_q;
  logic [4:0]  mrn_q;

  // MEM/WB register
  logic        wwreg_q, wm2reg_q, merr_q;
  logic        wwreg_d, wm2reg_d, merr_d;
  logic [31:0] walu_q, wmo_q, walu_d, wmo_d;
  logic [4:0]  wrn_q, wrn_d;

  logic        mem_op_s, misalign_s, req_s, rdy_s, abort_s, stall_s;

  assign mem_op_s = mm2reg_q | mwmem_q;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign_s = mem_op_s & (malu_q[1:0] != 2'b00);
`else
  assign misalign_s = 1'b0;
`endif

  // Both FSM states issue the request. A trapped misaligned op never does.
  assign req_s   = mem_op_s & ~misalign_s & ((state_q == S_IDLE) | (state_q == S_WAIT));
  // A ready pulse without a request is ignored.
  assign rdy_s   = dmem_ready & req_s;
  // Ready in the same cycle as the timeout wins over the abort.
  assign abort_s = misalign_s |
                   (req_s & ~dmem_ready & (state_q == S_WAIT) & (cnt_q >= TIMEOUT_C));
  assign stall_s = mem_op_s & ~rdy_s & ~abort_s;

  assign dmem_req   = req_s;
  assign dmem_we    = mwmem_q;
  assign dmem_addr  = {malu_q[31:2], 2'b00};
  assign dmem_wdata = mb_q;
  assign stall_mem  = stall_s;

  assign mwreg  = mwreg_q;
  assign mm2reg = mm2reg_q;
  assign malu   = malu_q;
  assign mrn    = mrn_q;
  assign wwreg  = wwreg_q;
  assign wm2reg = wm2reg_q;
  assign walu   = walu_q;
  assign wmo    = wmo_q;
  assign wrn    = wrn_q;
  assign merr   = merr_q;

  // Access FSM next state and wait-cycle counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_s & ~rdy_s & ~abort_s) begin
          state_d = S_WAIT;
          cnt_d   = 8'd1;
        end else begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end
      end
      S_WAIT: begin
        // ~req_s cannot happen while waiting; leave WAIT safely if it does.
        if (rdy_s | abort_s | ~req_s) begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end else if (cnt_q == 8'hFF) begin
          state_d = S_WAIT;
          cnt_d   = cnt_q;
        end else begin
          state_d = S_WAIT;
          cnt_d   = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // MEM/WB next value: bubble while stalled, error record on abort
  always_comb begin
    wwreg_d  = wwreg_q;
    wm2reg_d = wm2reg_q;
    walu_d   = walu_q;
    wmo_d    = wmo_q;
    wrn_d    = wrn_q;
    merr_d   = abort_s;
    if (stall_s) begin
      wwreg_d  = 1'b0;
      wm2reg_d = 1'b0;
    end else if (abort_s) begin
      wwreg_d  = 1'b0;
      wm2reg_d = mm2reg_q;
      walu_d   = malu_q;
      wmo_d    = ERR_DATA;
      wrn_d    = mrn_q;
    end else begin
      wwreg_d  = mwreg_q;
      wm2reg_d = mm2reg_q;
      walu_d   = malu_q;
      wmo_d    = (mm2reg_q & ~mwmem_q) ? dmem_rdata : 32'h0000_0000;
      wrn_d    = mrn_q;
    end
  end

  // FSM state and counter registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // EX/MEM register: holds while the access stalls
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mwreg_q  <= 1'b0;
      mm2reg_q <= 1'b0;
      mwmem_q  <= 1'b0;
      malu_q   <= 32'h0000_0000;
      mb_q     <= 32'h0000_0000;
      mrn_q    <= 5'd0;
    end else if (!stall_s) begin
      mwreg_q  <= ewreg;
      mm2reg_q <= em2reg;
      mwmem_q  <= ewmem;
      malu_q   <= ealu;
      mb_q     <= eb;
      mrn_q    <= ern;
    end else begin
      mwreg_q  <= mwreg_q;
      mm2reg_q <= mm2reg_q;
      mwmem_q  <= mwmem_q;
      malu_q   <= malu_q;
      mb_q     <= mb_q;
      mrn_q    <= mrn_q;
    end
  end

  // MEM/WB register and error pulse
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wwreg_q  <= 1'b0;
      wm2reg_q <= 1'b0;
      walu_q   <= 32'h0000_0000;
      wmo_q    <= 32'h0000_0000;
      wrn_q    <= 5'd0;
      merr_q   <= 1'b0;
    end else begin
      wwreg_q  <= wwreg_d;
      wm2reg_q <= wm2reg_d;
      walu_q   <= walu_d;
      wmo_q    <= wmo_d;
      wrn_q    <= wrn_d;
      merr_q   <= merr_d;
    end
  end

endmodule

// File: tb/tb_pipemem_stage.sv
module tb_pipemem_stage;

  localparam int TMO = 10;
  localparam int NRAND = 400;

  logic        clock, resetn;
  logic        ewreg, em2reg, ewmem;
  logic [31:0] ealu, eb;
  logic [4:0]  ern;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        stall_mem, mwreg, mm2reg, wwreg, wm2reg, merr;
  logic [31:0] malu, walu, wmo;
  logic [4:0]  mrn, wrn;

  pipemem_stage #(.TIMEOUT(TMO), .ERR_DATA(32'hDEADBEEF)) dut (
    .clock(clock), .resetn(resetn),
    .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
    .ealu(ealu), .eb(eb), .ern(ern),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .stall_mem(stall_mem), .mwreg(mwreg), .mm2reg(mm2reg), .malu(malu), .mrn(mrn),
    .wwreg(wwreg), .wm2reg(wm2reg), .walu(walu), .wmo(wmo), .wrn(wrn), .merr(merr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int write_cnt = 0;
  bit rand_on = 1'b0;

  typedef struct {
    logic        wreg, m2reg, wmem;
    logic [31:0] alu, b;
    logic [4:0]  rn;
    logic        rdy;
    logic [31:0] rdata;
    logic        x_wwreg, x_wm2reg;
    logic [31:0] x_walu, x_wmo;
    logic [4:0]  x_wrn;
  } vec_t;

  typedef struct {
    logic [31:0] alu, mo;
    logic [4:0]  rn;
    logic        m2reg;
  } wb_t;

  wb_t         wbq[$];
  logic [63:0] stq[$];
  logic [31:0] mmem[16];   // reference: architectural memory in program order
  logic [31:0] bmem[16];   // bus-side memory updated only by observed writes

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_exe(input logic w, input logic l, input logic s,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] r);
    ewreg = w; em2reg = l; ewmem = s; ealu = a; eb = b; ern = r;
  endtask

  task automatic nop();
    set_exe(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Bus-side observer: counts writes, keeps the bus memory, and checks stores
  always @(posedge clock) begin
    if (resetn && dmem_req && dmem_we && dmem_ready) begin
      logic [63:0] w;
      write_cnt++;
      bmem[dmem_addr[5:2]] = dmem_wdata;
      if (rand_on) begin
        if (stq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL st_unexpected: got write %0h to %0h expected none", dmem_wdata, dmem_addr);
        end else begin
          w = stq.pop_front();
          chk("st_addr", dmem_addr, w[63:32]);
          chk("st_data", dmem_wdata, w[31:0]);
        end
      end
    end
  end

  vec_t vecs[5];

  // random-phase state
  int          kind, lat, waited, n, w0;
  bit          acc, busy, phantom;
  logic [31:0] r_addr, r_data, rq_addr, rq_wdata;
  logic        rq_we;
  wb_t         e;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd5, 1'b0, 32'h0,
                1'b1, 1'b0, 32'h1234, 32'h0, 5'd5};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd7, 1'b1, 32'hCAFEF00D,
                1'b1, 1'b1, 32'h40, 32'hCAFEF00D, 5'd7};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h80, 32'h55, 5'd0, 1'b1, 32'hFFFFFFFF,
                1'b0, 1'b0, 32'h80, 32'h0, 5'd0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h0, 5'd31, 1'b1, 32'hAAAA,
                1'b0, 1'b0, 32'hFFFFFFFF, 32'h0, 5'd31};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0,
                1'b1, 1'b0, 32'h0, 32'h0, 5'd0};

    // ---------------- reset state ----------------
    resetn = 1'b0; dmem_ready = 1'b0; dmem_rdata = 32'h0; nop();
    @(negedge clock); @(negedge clock);
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_stall", {31'd0, stall_mem}, 32'd0);
    chk("rst_ctrl", {26'd0, mwreg, mm2reg, wwreg, wm2reg, merr, 1'b0}, 32'd0);
    chk("rst_malu", malu, 32'd0);
    chk("rst_walu", walu, 32'd0);
    chk("rst_wmo", wmo, 32'd0);
    chk("rst_rn", {22'd0, mrn, wrn}, 32'd0);
    resetn = 1'b1;
    @(negedge clock);

    // ---------------- table-driven single instructions ----------------
    for (int i = 0; i < 5; i++) begin
      set_exe(vecs[i].wreg, vecs[i].m2reg, vecs[i].wmem, vecs[i].alu, vecs[i].b, vecs[i].rn);
      dmem_ready = vecs[i].rdy; dmem_rdata = vecs[i].rdata;
      step();
      nop();
      #1;
      chk($sformatf("v%0d_stall", i), {31'd0, stall_mem}, 32'd0);
      chk($sformatf("v%0d_malu", i), malu, vecs[i].alu);
      chk($sformatf("v%0d_mrn", i), {27'd0, mrn}, {27'd0, vecs[i].rn});
      chk($sformatf("v%0d_req", i), {31'd0, dmem_req}, {31'd0, vecs[i].m2reg | vecs[i].wmem});
      step();
      chk($sformatf("v%0d_wwreg", i), {31'd0, wwreg}, {31'd0, vecs[i].x_wwreg});
      chk($sformatf("v%0d_wm2reg", i), {31'd0, wm2reg}, {31'd0, vecs[i].x_wm2reg});
      chk($sformatf("v%0d_walu", i), walu, vecs[i].x_walu);
      chk($sformatf("v%0d_wmo", i), wmo, vecs[i].x_wmo);
      chk($sformatf("v%0d_wrn", i), {27'd0, wrn}, {27'd0, vecs[i].x_wrn});
      dmem_ready = 1'b0;
    end
    step();

    // ---------------- store with 3 wait cycles ----------------
    set_exe(1'b1, 1'b0, 1'b0, 32'h777, 32'h0, 5'd9);
    step();
    set_exe(1'b0, 1'b0, 1'b1, 32'h80, 32'h55, 5'd0);
    step();
    nop();
    w0 = write_cnt;
    #1;
    chk("st3_alu_in_wb", {31'd0, wwreg}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("st3_stall%0d", k), {31'd0, stall_mem}, 32'd1);
      chk($sformatf("st3_req%0d", k), {30'd0, dmem_req, dmem_we}, 32'd3);
      chk($sformatf("st3_addr%0d", k), dmem_addr, 32'h80);
      chk($sformatf("st3_wdata%0d", k), dmem_wdata, 32'h55);
      step();
      chk($sformatf("st3_bubble%0d", k), {30'd0, wwreg, wm2reg}, 32'd0);
    end
    dmem_ready = 1'b1;
    #1;
    chk("st3_stall_done", {31'd0, stall_mem}, 32'd0);
    step();
    dmem_ready = 1'b0;
    chk("st3_wwreg", {31'd0, wwreg}, 32'd0);
    chk("st3_walu", walu, 32'h80);
    chk("st3_wmo", wmo, 32'd0);
    chk("st3_writes", write_cnt - w0, 32'd1);
    step();

    // ---------------- load that never completes ----------------
    set_exe(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 5'd3);
    step();
    nop();
    #1;
    n = 0;
    while (stall_mem && n < 50) begin
      n++;
      step();
      #1;
    end
    chk("tmo_stall_cycles", n, TMO);
    chk("tmo_merr_before", {31'd0, merr}, 32'd0);
    step();
    chk("tmo_merr", {31'd0, merr}, 32'd1);
    chk("tmo_wmo", wmo, 32'hDEADBEEF);
    chk("tmo_wwreg", {31'd0, wwreg}, 32'd0);
    chk("tmo_walu", walu, 32'h100);
    step();
    chk("tmo_merr_pulse", {31'd0, merr}, 32'd0);

    // ---------------- misaligned load ----------------
    set_exe(1'b1, 1'b1, 1'b0, 32'h42, 32'h0, 5'd4);
    step();
    nop();
    dmem_ready = 1'b1; dmem_rdata = 32'h12345678;
    #1;
`ifdef MEM_MISALIGN_TRAP_EN
    chk("mis_req", {31'd0, dmem_req}, 32'd0);
    chk("mis_stall", {31'd0, stall_mem}, 32'd0);
    step();
    chk("mis_merr", {31'd0, merr}, 32'd1);
    chk("mis_wmo", wmo, 32'hDEADBEEF);
    chk("mis_wwreg", {31'd0, wwreg}, 32'd0);
`else
    chk("mis_req", {31'd0, dmem_req}, 32'd1);
    chk("mis_addr", dmem_addr, 32'h40);
    step();
    chk("mis_merr", {31'd0, merr}, 32'd0);
    chk("mis_wmo", wmo, 32'h12345678);
    chk("mis_wwreg", {31'd0, wwreg}, 32'd1);
`endif
    dmem_ready = 1'b0;
    step(); step();

    // ---------------- randomized run against reference model ----------------
    for (int i = 0; i < 16; i++) begin
      mmem[i] = (i * 32'h01010101) ^ 32'h5A5A0000;
      bmem[i] = mmem[i];
    end
    rand_on = 1'b1;
    acc = 1'b1; busy = 1'b0; kind = 3; waited = 0; lat = 0;
    for (int cyc = 0; cyc < NRAND + 20; cyc++) begin
      if (acc) begin
        kind = (cyc < NRAND) ? int'($urandom_range(0, 3)) : 3;
        r_addr = $urandom();
        r_addr[1:0] = 2'b00;
        r_data = $urandom();
        case (kind)
          0: set_exe(1'b1, 1'b0, 1'b0, r_addr ^ 32'h3, r_data, 5'($urandom()));
          1: set_exe(1'b1, 1'b1, 1'b0, r_addr, r_data, 5'($urandom()));
          2: set_exe(1'b0, 1'b0, 1'b1, r_addr, r_data, 5'($urandom()));
          default: nop();
        endcase
      end
      // memory responder with random latency; random ready noise when idle
      if (dmem_req) begin
        if (!busy) begin
          busy = 1'b1; waited = 0; lat = int'($urandom_range(0, 3));
          rq_addr = dmem_addr; rq_we = dmem_we; rq_wdata = dmem_wdata;
        end else begin
          chk("req_hold_addr", dmem_addr, rq_addr);
          chk("req_hold_wdata", {dmem_wdata}, rq_we ? rq_wdata : dmem_wdata);
          chk("req_hold_we", {31'd0, dmem_we}, {31'd0, rq_we});
        end
        dmem_ready = (waited == lat);
        dmem_rdata = (dmem_ready && !dmem_we) ? bmem[dmem_addr[5:2]] : $urandom();
        if (dmem_ready) busy = 1'b0;
        else waited++;
      end else begin
        busy = 1'b0;
        dmem_ready = 1'($urandom_range(0, 1));
        dmem_rdata = $urandom();
      end
      #1;
      chk("rnd_stall", {31'd0, stall_mem}, {31'd0, dmem_req & ~dmem_ready});
      if (wwreg) begin
        if (wbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wb_unexpected: got write-back rn %0d expected none", wrn);
        end else begin
          e = wbq.pop_front();
          chk("rnd_walu", walu, e.alu);
          chk("rnd_wmo", wmo, e.mo);
          chk("rnd_wrn", {27'd0, wrn}, {27'd0, e.rn});
          chk("rnd_wm2reg", {31'd0, wm2reg}, {31'd0, e.m2reg});
        end
      end
      acc = !stall_mem;
      if (acc) begin
        case (kind)
          0: wbq.push_back('{ealu, 32'h0, ern, 1'b0});
          1: wbq.push_back('{ealu, mmem[ealu[5:2]], ern, 1'b1});
          2: begin
            mmem[ealu[5:2]] = eb;
            stq.push_back({ealu, eb});
          end
          default: ;
        endcase
      end
      @(negedge clock);
    end
    chk("rnd_wb_drained", wbq.size(), 32'd0);
    chk("rnd_st_drained", stq.size(), 32'd0);
    rand_on = 1'b0;
    dmem_ready = 1'b0;
    nop();
    step();

    // ---------------- reset in the middle of a wait ----------------
    set_exe(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 5'd2);
    step();
    nop();
    step();
    #1;
    chk("rstw_req_before", {31'd0, dmem_req}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("rstw_req", {31'd0, dmem_req}, 32'd0);
    chk("rstw_stall", {31'd0, stall_mem}, 32'd0);
    chk("rstw_ctrl", {27'd0, mwreg, mm2reg, wwreg, wm2reg, merr}, 32'd0);
    chk("rstw_data", malu | walu | wmo, 32'd0);
    chk("rstw_rn", {22'd0, mrn, wrn}, 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    phantom = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      #1;
      phantom = phantom | dmem_req | stall_mem;
    end
    chk("rstw_no_phantom", {31'd0, phantom}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
